// File: rtl/keypad_scanner.sv
// keypad_scanner: tick-paced 4x4 matrix keypad scanner with press/release debounce and one-shot key codes
module keypad_scanner #(
  parameter int SCAN_DIV       = 1349,
  parameter int DEBOUNCE_TICKS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] filas,
  output logic [3:0] columnas,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);
  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    col_q, col_d, row_q, row_d, row_idx;
  logic [3:0]    s1_q, rs_q, code_q, code_d;
  logic          valid_q, valid_d, pressed_q;
  logic          tick, any_low, same_row, done;
  always_comb begin
    tick     = div_q == DW'(SCAN_DIV);
    div_d    = tick ? '0 : div_q + 1'b1;
    any_low  = rs_q != 4'b1111;
    row_idx  = !rs_q[0] ? 2'd0 : !rs_q[1] ? 2'd1 : !rs_q[2] ? 2'd2 : 2'd3;
    same_row = any_low && row_idx == row_q;
    done     = cnt_q + 1'b1 == CW'(DEBOUNCE_TICKS);
    state_d  = state_q;
    cnt_d    = cnt_q;
    col_d    = col_q;
    row_d    = row_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    if (tick)
      case (state_q)
        SCAN:
          if (any_low) begin
            row_d   = row_idx;
            cnt_d   = CW'(1);
            state_d = DEBOUNCE;
          end else
            col_d = col_q + 1'b1;
        DEBOUNCE:
          if (!same_row) begin
            cnt_d   = '0;
            col_d   = col_q + 1'b1;
            state_d = SCAN;
          end else if (done) begin
            code_d  = {row_q, col_q};
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = HELD;
          end else
            cnt_d = cnt_q + 1'b1;
        HELD:
          if (any_low)
            cnt_d = '0;
          else if (done) begin
            cnt_d   = '0;
            col_d   = col_q + 1'b1;
            state_d = SCAN;
          end else
            cnt_d = cnt_q + 1'b1;
        default: state_d = SCAN;
      endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      div_q     <= '0;
      cnt_q     <= '0;
      col_q     <= 2'd0;
      row_q     <= 2'd0;
      s1_q      <= 4'b1111;
      rs_q      <= 4'b1111;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
      state_q   <= SCAN;
    end else begin
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      s1_q      <= filas;
      rs_q      <= s1_q;
      code_q    <= code_d;
      valid_q   <= valid_d;
      pressed_q <= state_d == HELD;
      state_q   <= state_d;
    end
  assign columnas    = ~(4'b0001 << col_q);
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_pressed = pressed_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: per-cycle model comparison plus directed keypad scenarios with literal expectations
module tb_keypad_scanner;
  localparam int SD = 3;
  localparam int DT = 4;
  logic       clk = 1'b0, reset = 1'b1, started = 1'b0;
  logic [3:0] filas, columnas, key_code;
  logic       key_valid, key_pressed;
  logic [3:0] row_mask = 4'd0, ovr = 4'hF;
  logic       ovr_en = 1'b0;
  int         key_col = 0;
  int         checks = 0, errors = 0, pulses = 0;
  int         m_div, m_col, m_mode, m_run, m_row, m_code, r;
  logic [3:0] m_s1, m_rs;
  logic       m_valid, m_pressed, low;
  logic [3:0] idle_cols [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
    .clk(clk), .reset(reset), .filas(filas), .columnas(columnas),
    .key_code(key_code), .key_valid(key_valid), .key_pressed(key_pressed)
  );
  always #5 clk = ~clk;
  always_comb filas = ovr_en ? ovr : (row_mask != 4'd0 && !columnas[key_col]) ? ~row_mask : 4'hF;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (reset) begin
      m_div = 0; m_col = 0; m_mode = 0; m_run = 0; m_row = 0; m_code = 0;
      m_s1 = 4'hF; m_rs = 4'hF; m_valid = 1'b0; m_pressed = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (m_div == SD) begin
        m_div = 0;
        low = m_rs != 4'hF;
        r = 3;
        for (int i = 3; i >= 0; i--) if (!m_rs[i]) r = i;
        if (m_mode == 0) begin
          if (low) begin m_row = r; m_run = 1; m_mode = 1; end
          else m_col = (m_col + 1) % 4;
        end else if (m_mode == 1) begin
          if (low && r == m_row) begin
            m_run++;
            if (m_run == DT) begin m_code = m_row * 4 + m_col; m_valid = 1'b1; m_run = 0; m_mode = 2; end
          end else begin m_run = 0; m_col = (m_col + 1) % 4; m_mode = 0; end
        end else begin
          if (low) m_run = 0;
          else begin
            m_run++;
            if (m_run == DT) begin m_run = 0; m_col = (m_col + 1) % 4; m_mode = 0; end
          end
        end
      end else m_div++;
      m_rs = m_s1;
      m_s1 = filas;
      m_pressed = m_mode == 2;
    end
  end
  always @(negedge clk) if (started) begin
    check("columnas", columnas, 4'hF ^ (4'b0001 << m_col));
    check("key_code", key_code, m_code);
    check("key_valid", key_valid, m_valid);
    check("key_pressed", key_pressed, m_pressed);
    if (key_valid) pulses++;
  end
  initial begin
    @(posedge clk);
    started = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("idle_col", columnas, idle_cols[i]);
      repeat (4) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check("idle_pulses", pulses, 0);
    check("idle_pressed", key_pressed, 1'b0);
    row_mask = 4'b0100; key_col = 1;
    repeat (60) @(negedge clk);
    check("press9_pulses", pulses, 1);
    check("press9_code", key_code, 4'd9);
    check("press9_pressed", key_pressed, 1'b1);
    check("press9_cols", columnas, 4'b1101);
    ovr = 4'b1011; ovr_en = 1'b1;
    repeat (4) @(negedge clk);
    ovr = 4'hF;
    repeat (8) @(negedge clk);
    ovr = 4'b1011;
    repeat (4) @(negedge clk);
    ovr = 4'hF;
    repeat (8) @(negedge clk);
    check("release_hold", key_pressed, 1'b1);
    repeat (24) @(negedge clk);
    check("release_done", key_pressed, 1'b0);
    check("release_pulses", pulses, 1);
    ovr_en = 1'b0; row_mask = 4'b1010; key_col = 3;
    repeat (60) @(negedge clk);
    check("multi_code", key_code, 4'd7);
    check("multi_pulses", pulses, 2);
    check("multi_pressed", key_pressed, 1'b1);
    check("multi_cols", columnas, 4'b0111);
    row_mask = 4'd0;
    repeat (40) @(negedge clk);
    check("multi_release", key_pressed, 1'b0);
    ovr_en = 1'b1; ovr = 4'b1110;
    repeat (8) @(negedge clk);
    ovr = 4'hF;
    repeat (4) @(negedge clk);
    ovr = 4'b1110;
    repeat (12) @(negedge clk);
    check("bounce_nopulse", pulses, 2);
    repeat (30) @(negedge clk);
    check("bounce_pulse", pulses, 3);
    check("bounce_row", key_code[3:2], 2'd0);
    check("bounce_pressed", key_pressed, 1'b1);
    ovr = 4'hF;
    repeat (40) @(negedge clk);
    check("bounce_release", key_pressed, 1'b0);
    ovr = 4'b1101;
    for (int n = 0; n < 40 && m_mode != 1; n++) @(negedge clk);
    checks++;
    if (m_mode != 1) begin
      errors++;
      $display("FAIL reach_debounce: model mode %0d expected 1", m_mode);
    end
    repeat (8) @(negedge clk);
    reset = 1'b1; ovr = 4'hF;
    @(negedge clk);
    reset = 1'b0;
    check("rst_cols", columnas, 4'b1110);
    check("rst_code", key_code, 4'd0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_pressed", key_pressed, 1'b0);
    repeat (20) @(negedge clk);
    check("rst_pulses", pulses, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart to the display path: scans a 4x4 matrix keypad by driving columns and reading rows.
- Debounces presses and releases.
- Delivers one key code per press to the multiplier control logic.
- Column stepping is paced by an internal tick prescaler running from the 27 MHz system clock; no derived clocks.

Parameters:
- SCAN_DIV, 1349: tick period is SCAN_DIV+1 clk cycles (27 MHz -> 20 kHz column-step tick).
- DEBOUNCE_TICKS, 16: number of consecutive stable ticks required to accept a press and to accept a release.

Ports:
- clk  input  1  system clock, 27 MHz; single clock domain.
- reset  input  1  synchronous, active-high reset.
- filas  input  4  keypad rows; active-low; pulled up externally; asynchronous to clk.
- columnas  output  4  keypad column drive; active-low, exactly one bit low at all times.
- key_code  output  4  code of last accepted key = row_idx*4 + col_idx.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_pressed  output  1  high while an accepted key is held (HELD state).

Behaviour:
- Reset, synchronous and active-high, sampled on posedge clk; all state is cleared in the same edge:
  - tick counter = 0; col_idx = 0; columnas = 4'b1110.
  - row synchronizer = 4'b1111; state = SCAN; debounce counter = 0.
  - key_code = 0; key_valid = 0; key_pressed = 0.
- Reset asserted mid-operation abandons any press in progress with no key_valid pulse.
- Prescaler:
  - Counter runs 0..SCAN_DIV, width $clog2(SCAN_DIV+1).
  - tick = 1 for the single cycle where counter == SCAN_DIV; the counter then wraps to 0.
- Row input: 2-flop synchronizer on filas; all decisions use the synchronized value rs.
- Row decode:
  - any_low = (rs != 4'b1111).
  - row_idx = index of the lowest-numbered low bit; with multiple rows low, the lowest index wins.
- columnas = ~(4'b0001 << col_idx). It changes only on a tick, so rows have a full tick period to settle before the next sample.
- FSM; transitions happen only on tick cycles, otherwise state holds:
  - SCAN:
    - If any_low: latch cand_row = row_idx and cand_col = col_idx, set cnt = 1, go DEBOUNCE. col_idx is frozen.
    - Else: col_idx = col_idx+1, wrapping 3 -> 0.
  - DEBOUNCE:
    - If any_low and row_idx == cand_row: cnt++.
      - When cnt reaches DEBOUNCE_TICKS: key_code = {cand_row, cand_col}, key_valid = 1 for the next clk cycle only, cnt = 0, go HELD.
    - Else (bounce or row changed): cnt = 0, col_idx advances, go SCAN. No output.
  - HELD:
    - key_pressed = 1.
    - If !any_low: cnt++; when cnt reaches DEBOUNCE_TICKS, cnt = 0, col_idx advances, go SCAN.
    - If any_low: cnt = 0 (release glitch rejected).
- key_pressed = (state == HELD), registered.
- key_code holds its value until the next accepted key; it is never cleared except by reset.
- Latency:
  - Press accepted DEBOUNCE_TICKS ticks after the first sample.
  - key_valid rises in the clk cycle after the accepting tick.
  - Synchronizer adds 2 cycles, which are absorbed within a tick period.
- A second key pressed while one is held is ignored until full release; no rollover.
- Debounce counter width: $clog2(DEBOUNCE_TICKS+1). DEBOUNCE_TICKS >= 1.

Test Plan:
- All benches use SCAN_DIV=3 and DEBOUNCE_TICKS=4.
- Idle: reset, filas=4'hF for 40 cycles -> columnas steps 1110, 1101, 1011, 0111, 1110, advancing every 4 cycles; key_valid never asserts; key_pressed=0.
- Clean press, row 2 / col 1 (key 9): model drives filas[2]=0 whenever columnas[1]=0 and holds it -> exactly one key_valid pulse with key_code=4'd9; key_pressed=1; columnas frozen at 1101 while held.
- Bounce: row low for 2 ticks, then high for 1 tick, then low steady -> no pulse from the first burst; one pulse after 4 further stable ticks.
- Release debounce: while HELD, filas high 2 ticks, low 1 tick, high 4 ticks -> key_pressed stays 1 until the 4th consecutive high tick, then drops to 0 and scanning resumes; no extra key_valid.
- Multiple rows: rows 1 and 3 both low on col 3 -> key_code=4'd7 (row 1 wins).
- Reset mid-DEBOUNCE: assert reset for 1 cycle after 2 stable ticks -> all outputs return to reset values, columnas=1110, no key_valid pulse.
